// File: rtl/vai_pkg.sv
// Shared VAI definitions: header codes, default byte-stuffing codes and the framer state type.
package vai_pkg;

   localparam logic [7:0] READ  = 8'h00;
   localparam logic [7:0] WRITE = 8'h01;

   localparam logic [7:0] VAI_SOF     = 8'h7B;
   localparam logic [7:0] VAI_EOF     = 8'h7D;
   localparam logic [7:0] VAI_ESC     = 8'h7C;
   localparam logic [7:0] VAI_ESC_XOR = 8'h20;

   // StDrop is a sub-state of idle that swallows bytes up to the next EOF.
   typedef enum logic [2:0] {
      StIdle,
      StOpen,
      StData,
      StEscp,
      StDrop
   } framer_state_e;

endpackage

// File: rtl/vai_out_slice.sv
// Single-entry VAI output register with Start/Stop sideband; contents hold while stalled.
module vai_out_slice #(
   parameter int unsigned Width = 8
) (
   input  logic             Clk_i,
   input  logic             Reset_n_i,
   input  logic             push_i,
   input  logic [Width-1:0] data_i,
   input  logic             start_i,
   input  logic             stop_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [Width-1:0] data_o,
   output logic             start_o,
   output logic             stop_o,
   input  logic             accept_i
);

   logic             valid_q;
   logic [Width-1:0] data_q;
   logic             start_q;
   logic             stop_q;

   // A push may coincide with the downstream accept of the current entry.
   assign ready_o = !valid_q || accept_i;

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end else if (push_i) begin
         valid_q <= 1'b1;
         data_q  <= data_i;
         start_q <= start_i;
         stop_q  <= stop_i;
      end else if (accept_i) begin
         // Sideband flags are cleared so they never show without valid.
         valid_q <= 1'b0;
         start_q <= 1'b0;
         stop_q  <= 1'b0;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign start_o = start_q;
   assign stop_o  = stop_q;

endmodule

// File: rtl/vai_byte_framer.sv
// Byte-stuffed stream to VAI frame converter; one byte of lookahead marks Stop on the last byte.
module vai_byte_framer
   import vai_pkg::*;
#(
   parameter logic [7:0]  SOF     = VAI_SOF,
   parameter logic [7:0]  EOF     = VAI_EOF,
   parameter logic [7:0]  ESC     = VAI_ESC,
   parameter logic [7:0]  ESC_XOR = VAI_ESC_XOR,
   parameter int unsigned MAX_LEN = 16
) (
   input  logic       Reset_n_i,
   input  logic       Clk_i,
   input  logic [7:0] RxData_i,
   input  logic       RxValid_i,
   output logic       RxAccept_o,
   output logic [7:0] Dout_o,
   output logic       DoutValid_o,
   output logic       DoutStart_o,
   output logic       DoutStop_o,
   input  logic       DoutAccept_i,
   output logic       FrameErr_o
);

   localparam logic [7:0] MaxLen = 8'(MAX_LEN);

   framer_state_e state_q, state_d;
   logic [7:0]    hold_q, hold_d;
   logic          first_q, first_d;
   logic          held_q, held_d;
   logic [7:0]    len_q, len_d;
   logic          err_q, err_d;

   logic       rx_ready;
   logic       rx_fire;
   logic       is_sof, is_eof, is_esc;
   logic       take;
   logic [7:0] payload;
   logic       push;
   logic [7:0] push_data;
   logic       push_start;
   logic       push_stop;

   assign rx_fire    = RxValid_i && rx_ready;
   assign RxAccept_o = rx_ready;
   assign is_sof     = (RxData_i == SOF);
   assign is_eof     = (RxData_i == EOF);
   assign is_esc     = (RxData_i == ESC);

   always_comb begin
      state_d    = state_q;
      hold_d     = hold_q;
      first_d    = first_q;
      held_d     = held_q;
      len_d      = len_q;
      err_d      = 1'b0;
      take       = 1'b0;
      payload    = RxData_i;
      push       = 1'b0;
      push_data  = hold_q;
      push_start = first_q;
      push_stop  = 1'b0;

      if (rx_fire) begin
         unique case (state_q)
            StIdle: begin
               if (is_sof) state_d = StOpen;
            end
            StDrop: begin
               if (is_sof)      state_d = StOpen;
               else if (is_eof) state_d = StIdle;
            end
            StOpen, StData: begin
               if (is_esc) begin
                  state_d = StEscp;
               end else if (is_eof) begin
                  // An EOF with nothing held means the frame was empty.
                  push      = held_q;
                  push_stop = 1'b1;
                  err_d     = !held_q;
                  held_d    = 1'b0;
                  len_d     = '0;
                  state_d   = StIdle;
               end else if (is_sof) begin
                  push      = held_q;
                  push_stop = 1'b1;
                  err_d     = held_q;
                  held_d    = 1'b0;
                  len_d     = '0;
                  state_d   = StOpen;
               end else begin
                  take = 1'b1;
               end
            end
            StEscp: begin
               if (is_sof || is_eof) begin
                  push      = held_q;
                  push_stop = 1'b1;
                  err_d     = 1'b1;
                  held_d    = 1'b0;
                  len_d     = '0;
                  state_d   = is_sof ? StOpen : StIdle;
               end else begin
                  take    = 1'b1;
                  payload = RxData_i ^ ESC_XOR;
               end
            end
            default: state_d = StIdle;
         endcase

         if (take) begin
            if (!held_q) begin
               hold_d  = payload;
               first_d = 1'b1;
               held_d  = 1'b1;
               len_d   = 8'd1;
               state_d = StData;
            end else if (len_q == MaxLen) begin
               // Overlength: close what we have, drop the rest of the frame.
               push      = 1'b1;
               push_stop = 1'b1;
               err_d     = 1'b1;
               held_d    = 1'b0;
               len_d     = '0;
               state_d   = StDrop;
            end else begin
               push    = 1'b1;
               hold_d  = payload;
               first_d = 1'b0;
               len_d   = len_q + 8'd1;
               state_d = StData;
            end
         end
      end
   end

   always_ff @(posedge Clk_i or negedge Reset_n_i) begin
      if (!Reset_n_i) begin
         state_q <= StIdle;
         hold_q  <= '0;
         first_q <= 1'b0;
         held_q  <= 1'b0;
         len_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         first_q <= first_d;
         held_q  <= held_d;
         len_q   <= len_d;
         err_q   <= err_d;
      end
   end

   assign FrameErr_o = err_q;

   vai_out_slice #(
      .Width(8)
   ) u_out_slice (
      .Clk_i    (Clk_i),
      .Reset_n_i(Reset_n_i),
      .push_i   (push),
      .data_i   (push_data),
      .start_i  (push_start),
      .stop_i   (push_stop),
      .ready_o  (rx_ready),
      .valid_o  (DoutValid_o),
      .data_o   (Dout_o),
      .start_o  (DoutStart_o),
      .stop_o   (DoutStop_o),
      .accept_i (DoutAccept_i)
   );

endmodule

// File: tb/tb_vai_byte_framer.sv
// Bench for vai_byte_framer: directed and random byte streams against a frame-level model.
module tb_vai_byte_framer;

   localparam int MaxLen = 16;

   logic       Clk = 1'b0;
   logic       Reset_n = 1'b0;
   logic [7:0] RxData = 8'h00;
   logic       RxValid = 1'b0;
   logic       RxAccept;
   logic [7:0] Dout;
   logic       DoutValid, DoutStart, DoutStop;
   logic       DoutAccept = 1'b1;
   logic       FrameErr;

   int errors = 0;
   int checks = 0;
   int acc_mode = 0;  // 0: always accept, 1: random, 2: stall

   logic [9:0] exp_q[$];
   logic [9:0] got_q[$];
   int         err_exp = 0;
   int         err_seen = 0;

   // Frame-level model state: 0 idle, 1 inside a frame, 2 dropping to EOF.
   int         m_mode = 0;
   bit         m_esc = 0;
   logic [7:0] m_cur[$];

   always #5 Clk = ~Clk;

   vai_byte_framer #(
      .MAX_LEN(MaxLen)
   ) dut (
      .Reset_n_i   (Reset_n),
      .Clk_i       (Clk),
      .RxData_i    (RxData),
      .RxValid_i   (RxValid),
      .RxAccept_o  (RxAccept),
      .Dout_o      (Dout),
      .DoutValid_o (DoutValid),
      .DoutStart_o (DoutStart),
      .DoutStop_o  (DoutStop),
      .DoutAccept_i(DoutAccept),
      .FrameErr_o  (FrameErr)
   );

   always @(negedge Clk) begin
      case (acc_mode)
         0:       DoutAccept = 1'b1;
         1:       DoutAccept = 1'($urandom_range(0, 1));
         default: DoutAccept = 1'b0;
      endcase
   end

   // Monitor: collects transfers and error pulses, checks handshake invariants.
   logic       prev_hold = 1'b0;
   logic [9:0] prev_out = '0;
   always @(negedge Clk) begin
      #2;
      if (Reset_n) begin
         if (FrameErr) err_seen++;
         if (DoutValid && DoutAccept) got_q.push_back({Dout, DoutStart, DoutStop});
         if (prev_hold) begin
            checks++;
            assert ({DoutValid, Dout, DoutStart, DoutStop} === {1'b1, prev_out}) else begin
               errors++;
               $error("FAIL stable: got %h want %h", {DoutValid, Dout, DoutStart, DoutStop},
                      {1'b1, prev_out});
            end
         end
         checks++;
         assert (((DoutStart || DoutStop) && !DoutValid) === 1'b0) else begin
            errors++;
            $error("FAIL flags_without_valid: start=%b stop=%b valid=%b", DoutStart, DoutStop,
                   DoutValid);
         end
         checks++;
         assert (RxAccept === (!DoutValid || DoutAccept)) else begin
            errors++;
            $error("FAIL rx_accept: got %b want %b", RxAccept, !DoutValid || DoutAccept);
         end
         prev_hold = DoutValid && !DoutAccept;
         prev_out  = {Dout, DoutStart, DoutStop};
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic m_emit();
      foreach (m_cur[i])
         exp_q.push_back({m_cur[i], 1'(i == 0), 1'(i == m_cur.size() - 1)});
      m_cur.delete();
   endtask

   task automatic m_payload(input logic [7:0] p);
      if (m_cur.size() == MaxLen) begin
         m_emit();
         err_exp++;
         m_mode = 2;
      end else begin
         m_cur.push_back(p);
      end
   endtask

   task automatic m_byte(input logic [7:0] b);
      if (m_mode == 0) begin
         if (b == 8'h7B) begin m_mode = 1; m_esc = 0; m_cur.delete(); end
      end else if (m_mode == 2) begin
         if (b == 8'h7B) begin m_mode = 1; m_esc = 0; m_cur.delete(); end
         else if (b == 8'h7D) m_mode = 0;
      end else if (m_esc) begin
         m_esc = 0;
         if (b == 8'h7B || b == 8'h7D) begin
            m_emit();
            err_exp++;
            m_mode = (b == 8'h7B) ? 1 : 0;
         end else begin
            m_payload(b ^ 8'h20);
         end
      end else if (b == 8'h7C) begin
         m_esc = 1;
      end else if (b == 8'h7D) begin
         if (m_cur.size() == 0) err_exp++;
         m_emit();
         m_mode = 0;
      end else if (b == 8'h7B) begin
         if (m_cur.size() != 0) err_exp++;
         m_emit();
      end else begin
         m_payload(b);
      end
   endtask

   task automatic model(input logic [7:0] s[$]);
      foreach (s[i]) m_byte(s[i]);
   endtask

   // Called right after a negedge; returns right after the negedge following the last handshake.
   task automatic send(input logic [7:0] s[$], input bit gaps);
      foreach (s[i]) begin
         int budget;
         bit acc;
         if (gaps) begin
            RxValid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge Clk);
         end
         RxValid = 1'b1;
         RxData  = s[i];
         budget  = 0;
         forever begin
            #1;
            acc = RxAccept;
            @(negedge Clk);
            if (acc) break;
            budget++;
            if (budget > 200) begin
               checks++;
               assert (acc === 1'b1) else begin
                  errors++;
                  $error("FAIL rx_timeout: byte %h never accepted", s[i]);
               end
               break;
            end
         end
      end
      RxValid = 1'b0;
   endtask

   task automatic check_results(input string tag);
      int n;
      RxValid  = 1'b0;
      acc_mode = 0;
      repeat (12) @(negedge Clk);
      #3;
      checks++;
      assert (got_q.size() === exp_q.size()) else begin
         errors++;
         $error("FAIL %s_count: got %0d want %0d", tag, got_q.size(), exp_q.size());
      end
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         checks++;
         assert (got_q[i] === exp_q[i]) else begin
            errors++;
            $error("FAIL %s_byte%0d: got data=%h s=%b p=%b want data=%h s=%b p=%b", tag, i,
                   got_q[i][9:2], got_q[i][1], got_q[i][0], exp_q[i][9:2], exp_q[i][1],
                   exp_q[i][0]);
         end
      end
      checks++;
      assert (err_seen === err_exp) else begin
         errors++;
         $error("FAIL %s_errs: got %0d want %0d", tag, err_seen, err_exp);
      end
      got_q.delete();
      exp_q.delete();
      err_seen = 0;
      err_exp  = 0;
   endtask

   task automatic run(input logic [7:0] s[$], input bit gaps, input string tag);
      model(s);
      send(s, gaps);
      check_results(tag);
   endtask

   initial begin
      logic [7:0] s[$];
      int         len, r;

      #2;
      checks++;
      assert ({DoutValid, DoutStart, DoutStop, Dout, FrameErr, RxAccept} === {12'h000, 1'b0, 1'b1})
      else begin
         errors++;
         $error("FAIL reset: got v=%b s=%b p=%b d=%h e=%b acc=%b want all 0, acc=1", DoutValid,
                DoutStart, DoutStop, Dout, FrameErr, RxAccept);
      end
      repeat (2) @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      s = '{8'h7B, 8'h01, 8'hAA, 8'h55, 8'h7D};
      run(s, 0, "basic");
      s = '{8'h7B, 8'h00, 8'h7D};
      run(s, 0, "single");
      s = '{8'h7B, 8'h7C, 8'h5B, 8'h7D};
      run(s, 0, "escaped_sof");
      s = '{8'h7B, 8'h11, 8'h22, 8'h7B, 8'h33, 8'h7D};
      run(s, 0, "abort");
      s = '{8'h7B, 8'h7D, 8'h7B};
      for (int i = 1; i <= 17; i++) s.push_back(8'(i));
      s.push_back(8'h44);
      s.push_back(8'h7D);
      run(s, 0, "overlength");
      s = '{8'h7B, 8'h12, 8'h7C, 8'h7D, 8'h7B, 8'h7C, 8'h7C, 8'h7D, 8'h99, 8'h7B, 8'h7C, 8'h7B,
            8'h7D};
      run(s, 0, "esc_errors");

      // Downstream stall mid-frame.
      s = '{8'h7B, 8'h01, 8'h02, 8'h03, 8'h7D};
      model(s);
      acc_mode = 2;
      @(negedge Clk);
      s = '{8'h7B, 8'h01, 8'h02};
      send(s, 0);
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++;
         assert ({RxAccept, DoutValid, Dout, DoutStart, DoutStop} === {2'b01, 8'h01, 2'b10})
         else begin
            errors++;
            $error("FAIL stall%0d: got acc=%b v=%b d=%h s=%b p=%b want acc=0 v=1 d=01 s=1 p=0", i,
                   RxAccept, DoutValid, Dout, DoutStart, DoutStop);
         end
         @(negedge Clk);
      end
      acc_mode = 1;
      s = '{8'h03, 8'h7D};
      send(s, 0);
      check_results("stall");

      // Random streams with random gaps and backpressure.
      for (int t = 0; t < 40; t++) begin
         s.delete();
         s.push_back(8'h7B);
         len = $urandom_range(1, 40);
         for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 99);
            if (r < 5)       s.push_back(8'h7B);
            else if (r < 10) s.push_back(8'h7D);
            else if (r < 16) s.push_back(8'h7C);
            else             s.push_back(8'($urandom));
         end
         s.push_back(8'h7D);
         acc_mode = 1;
         run(s, 1, "random");
      end

      // Reset in the middle of a frame clears the output at once.
      s = '{8'h7B, 8'h01, 8'h02, 8'h03};
      send(s, 0);
      #1;
      Reset_n = 1'b0;
      #1;
      checks++;
      assert ({DoutValid, DoutStart, DoutStop, Dout, FrameErr, RxAccept} === {12'h000, 1'b0, 1'b1})
      else begin
         errors++;
         $error("FAIL mid_reset: got v=%b s=%b p=%b d=%h e=%b acc=%b want all 0, acc=1",
                DoutValid, DoutStart, DoutStop, Dout, FrameErr, RxAccept);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
